// File: rtl/ext_bus_pkg.sv
// Shared state encoding and sizing helpers for the external-bus controller.
package ext_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_DATA,
    ST_DONE
  } state_t;

  // Wide enough for up to 256 beats per phase and the 0..15 wait range.
  localparam int CNT_W = 8;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/ext_bus_sync2.sv
// Two-flop synchroniser for the asynchronous pad ready strobe.
module ext_bus_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ext_bus_ctrl.sv
// Serialises core bus accesses into ADDR / WAIT / DATA beats on a narrow pad bus.
// Optional EXT_BUS_READY_EN adds a synchronised pad_rdy that extends WAIT.
//
// state | meaning
// IDLE  | waiting for req; captures we/addr/wdata
// ADDR  | driving address beats, MS beat first, ale high
// WAIT  | turnaround, pads released
// DATA  | driving write beats or sampling read beats
// DONE  | one-cycle ack, chip select dropped
module ext_bus_ctrl
  import ext_bus_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 4,
  parameter int PIN_W       = 4,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic [PIN_W-1:0]  pad_out,
  input  logic [PIN_W-1:0]  pad_in,
  output logic [PIN_W-1:0]  pad_oe,
  output logic              pad_ale,
  output logic              pad_we,
  output logic              pad_cs
`ifdef EXT_BUS_READY_EN
  ,
  input  logic              pad_rdy
`endif
);

  localparam int A      = ceil_div(ADDR_W, PIN_W);
  localparam int D      = ceil_div(DATA_W, PIN_W);
  localparam int AW_EXT = A * PIN_W;
  localparam int DW_EXT = D * PIN_W;

  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(A - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(D - 1);
  localparam logic [CNT_W-1:0] W_LAST = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  logic rdy_sync;
`ifdef EXT_BUS_READY_EN
  localparam bit USE_WAIT = 1'b1;
  ext_bus_sync2 u_rdy_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pad_rdy),
    .q    (rdy_sync)
  );
`else
  localparam bit USE_WAIT = (WAIT_CYCLES != 0);
  assign rdy_sync = 1'b1;
`endif

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                cnt_tc;
  logic                we_q;
  logic [AW_EXT-1:0]   addr_sh;
  logic [DW_EXT-1:0]   wdata_sh;
  logic [DW_EXT-1:0]   rd_sh;
  logic [DW_EXT-1:0]   rd_nxt;

  assign cnt_tc = (cnt == '0);
  assign rd_nxt = (rd_sh << PIN_W) | DW_EXT'(pad_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req) state_nxt = ST_ADDR;
      ST_ADDR: if (cnt_tc) state_nxt = USE_WAIT ? ST_WAIT : ST_DATA;
      ST_WAIT: if (cnt_tc && rdy_sync) state_nxt = ST_DATA;
      ST_DATA: if (cnt_tc) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Beat counter saturates at zero; each phase reloads it on its way out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      we_q     <= 1'b0;
      addr_sh  <= '0;
      wdata_sh <= '0;
      rd_sh    <= '0;
      rdata    <= '0;
    end else begin
      if (!cnt_tc) cnt <= cnt - 1'b1;
      case (state)
        ST_IDLE: begin
          if (req) begin
            cnt      <= A_LAST;
            we_q     <= we;
            addr_sh  <= AW_EXT'(addr);
            wdata_sh <= DW_EXT'(wdata);
          end
        end
        ST_ADDR: begin
          addr_sh <= addr_sh << PIN_W;
          if (cnt_tc) cnt <= USE_WAIT ? W_LAST : D_LAST;
        end
        ST_WAIT: begin
          if (cnt_tc && rdy_sync) cnt <= D_LAST;
        end
        ST_DATA: begin
          wdata_sh <= wdata_sh << PIN_W;
          if (!we_q) begin
            rd_sh <= rd_nxt;
            if (cnt_tc) rdata <= rd_nxt[DATA_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = (state != ST_IDLE);
    ack     = (state == ST_DONE);
    pad_cs  = (state == ST_ADDR) || (state == ST_WAIT) || (state == ST_DATA);
    pad_ale = (state == ST_ADDR);
    pad_we  = pad_cs & we_q;
    pad_oe  = '0;
    pad_out = '0;
    if (state == ST_ADDR) begin
      pad_oe  = '1;
      pad_out = addr_sh[AW_EXT-1 -: PIN_W];
    end else if ((state == ST_DATA) && we_q) begin
      pad_oe  = '1;
      pad_out = wdata_sh[DW_EXT-1 -: PIN_W];
    end
  end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Self-checking bench for ext_bus_ctrl: table vectors, random traffic against a beat model,
// and hand sequences for reset abort, back-to-back requests, wide/wait config and pad_rdy.
`timescale 1ns/1ps
module tb_ext_bus_ctrl;

  localparam int PW = 4;
  localparam int A0 = 3;
  localparam int D0 = 1;
`ifdef EXT_BUS_READY_EN
  localparam int W0 = 1;
`else
  localparam int W0 = 0;
`endif
  localparam int LAT0 = 5 + W0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req, we;
  logic [11:0] addr;
  logic [3:0]  wdata, rdata, pad_out, pad_in, pad_oe;
  logic        ack, busy, pad_ale, pad_we, pad_cs;

  logic        req1, we1;
  logic [9:0]  addr1;
  logic [7:0]  wdata1, rdata1;
  logic [3:0]  pad_out1, pad_in1, pad_oe1;
  logic        ack1, busy1, pad_ale1, pad_we1, pad_cs1;
`ifdef EXT_BUS_READY_EN
  logic        pad_rdy, pad_rdy1;
`endif

  ext_bus_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .pad_out(pad_out), .pad_in(pad_in),
    .pad_oe(pad_oe), .pad_ale(pad_ale), .pad_we(pad_we), .pad_cs(pad_cs)
`ifdef EXT_BUS_READY_EN
    , .pad_rdy(pad_rdy)
`endif
  );

  ext_bus_ctrl #(.ADDR_W(10), .DATA_W(8), .PIN_W(4), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ack(ack1), .busy(busy1), .pad_out(pad_out1), .pad_in(pad_in1),
    .pad_oe(pad_oe1), .pad_ale(pad_ale1), .pad_we(pad_we1), .pad_cs(pad_cs1)
`ifdef EXT_BUS_READY_EN
    , .pad_rdy(pad_rdy1)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] model_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // {ack, busy, cs, ale, we, oe[3:0], out[3:0], rdata[3:0]}
  function automatic logic [16:0] obs0(input bit mask_out, input bit mask_we);
    return {ack, busy, pad_cs, pad_ale, mask_we ? 1'b0 : pad_we, pad_oe,
            mask_out ? 4'h0 : pad_out, rdata};
  endfunction

  // Expected pad view in cycle c after acceptance, from the beat-phase arithmetic.
  function automatic logic [16:0] exp0(input bit w, input logic [11:0] a, input logic [3:0] d,
                                       input int c, input logic [3:0] rd_old,
                                       input logic [3:0] rd_new);
    logic [3:0] oe, out, rd;
    bit ack_e, busy_e, cs_e, ale_e;
    oe = 4'h0; out = 4'h0; rd = rd_old;
    ack_e = 1'b0; busy_e = 1'b1; cs_e = 1'b1; ale_e = 1'b0;
    if (c <= A0) begin
      ale_e = 1'b1;
      oe    = 4'hF;
      out   = 4'((a >> ((A0 - c) * PW)) & 12'hF);
    end else if (c <= A0 + W0) begin
      oe = 4'h0;
    end else if (c <= A0 + W0 + D0) begin
      if (w) begin
        oe  = 4'hF;
        out = d;
      end
    end else if (c == A0 + W0 + D0 + 1) begin
      ack_e = 1'b1; cs_e = 1'b0; rd = rd_new;
    end else begin
      busy_e = 1'b0; cs_e = 1'b0; rd = rd_new;
    end
    return {ack_e, busy_e, cs_e, ale_e, cs_e & w, oe, out, rd};
  endfunction

  task automatic run_txn(input bit w, input logic [11:0] a, input logic [3:0] d,
                         input logic [3:0] pin, output int ack_at);
    logic [3:0] rd_old, rd_new;
    bit in_rdata;
    int last;
    last   = A0 + W0 + D0 + 1;
    rd_old = model_rdata;
    rd_new = w ? rd_old : pin;
    ack_at = -1;
    @(negedge clk);
    check("accept_idle", busy, 1'b0);
    req = 1'b1; we = w; addr = a; wdata = d; pad_in = 4'($urandom);
    @(posedge clk);
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      in_rdata = !w && (c > A0 + W0) && (c <= A0 + W0 + D0);
      check("txn_cycle", obs0(in_rdata, c >= last), exp0(w, a, d, c, rd_old, rd_new));
      if (ack && ack_at < 0) ack_at = c;
      req = 1'b0; we = 1'($urandom); addr = 12'($urandom); wdata = 4'($urandom);
      pad_in = in_rdata ? pin : 4'($urandom);
    end
    model_rdata = rd_new;
  endtask

  typedef struct {
    bit         we;
    logic [11:0] addr;
    logic [3:0]  wdata;
    logic [3:0]  pin;
    logic [3:0]  exp_rdata;
  } vec_t;

  vec_t vecs[7];
  logic [11:0] exp1 [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ack_at, acks, first, second, idle_cnt;
    bit in_rd;
    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; pad_in = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; pad_in1 = '0;
`ifdef EXT_BUS_READY_EN
    pad_rdy = 1'b1; pad_rdy1 = 1'b1;
`endif
    model_rdata = 4'h0;
    vecs[0] = '{1'b1, 12'hA5C, 4'h7, 4'h0, 4'h0};
    vecs[1] = '{1'b0, 12'h123, 4'h0, 4'h9, 4'h9};
    vecs[2] = '{1'b1, 12'h456, 4'h3, 4'h1, 4'h9};
    vecs[3] = '{1'b1, 12'h000, 4'hF, 4'h2, 4'h9};
    vecs[4] = '{1'b0, 12'hFFF, 4'hA, 4'h0, 4'h0};
    vecs[5] = '{1'b0, 12'h800, 4'h0, 4'h5, 4'h5};
    vecs[6] = '{1'b1, 12'h7FF, 4'h0, 4'hC, 4'h5};
    exp1 = '{12'h7E6, 12'h7FE, 12'h7FE, 12'h400, 12'h400, 12'h400, 12'h400, 12'h800};

    repeat (3) @(negedge clk);
    check("reset_state", obs0(1'b0, 1'b0), 17'h0);
    check("reset_state_wide", {busy1, ack1, pad_cs1, pad_oe1, pad_out1, rdata1}, 19'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].pin, ack_at);
      check("vec_ack_latency", ack_at, LAT0);
      check("vec_rdata", rdata, vecs[i].exp_rdata);
    end

    // req held high through ack: second access after exactly one idle cycle
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 12'h3C3; wdata = 4'h6;
    acks = 0; first = -1; second = -1; idle_cnt = 0;
    for (int c = 1; c <= 30 && acks < 2; c++) begin
      @(negedge clk);
      if (ack) begin
        acks++;
        if (acks == 1) first = c;
        else begin
          second = c;
          req = 1'b0;
        end
      end else if (!busy && acks == 1) idle_cnt++;
    end
    check("b2b_acks", acks, 2);
    check("b2b_spacing", second - first, LAT0 + 1);
    check("b2b_idle_cycles", idle_cnt, 1);
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("b2b_no_third_ack", acks, 0);
    check("b2b_idle_after", busy, 1'b0);

    // reset during address beat 1 aborts the access
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 12'hA5C; wdata = 4'h7;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("rst_pre_beat1", {pad_ale, pad_out}, 5'h15);
    #1 rst_n = 1'b0;
    #1 check("rst_outputs", obs0(1'b0, 1'b0), 17'h0);
    @(posedge clk);
    #1 check("rst_held_no_ack", {ack, busy}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    model_rdata = 4'h0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack || busy) acks++;
    end
    check("rst_release_idle", acks, 0);

    // wide config: 10-bit addr, 8-bit data, two wait cycles
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h3FF;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      req1 = 1'b0; addr1 = 10'($urandom);
      in_rd = (c == 6) || (c == 7);
      if (c <= 8)
        check("wide_cycle", {ack1, pad_cs1, pad_ale1, pad_oe1, in_rd ? 4'h0 : pad_out1,
                             pad_we1 & pad_cs1}, exp1[c-1]);
      if (c == 7) check("wide_rdata_mid", rdata1, 8'h00);
      if (c == 8) check("wide_rdata", rdata1, 8'hBE);
      if (c == 9) check("wide_idle", busy1, 1'b0);
      pad_in1 = (c == 6) ? 4'hB : (c == 7) ? 4'hE : 4'($urandom);
    end

`ifdef EXT_BUS_READY_EN
    // pad_rdy held low: WAIT persists until two cycles after the rise
    pad_rdy = 1'b0;
    repeat (3) @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 12'h5A5; wdata = 4'h3;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      req = 1'b0;
      if (c >= 4 && c <= 11) check("rdy_wait", {ack, pad_cs, pad_ale, pad_oe}, 7'b0100000);
      if (c == 12) check("rdy_data", {ack, pad_cs, pad_oe, pad_out}, 10'b0_1_1111_0011);
      if (c == 13) check("rdy_ack", ack, 1'b1);
      if (c == 9) pad_rdy = 1'b1;
    end
`endif

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(1'($urandom), 12'($urandom), 4'($urandom), 4'($urandom), ack_at);
      check("rand_ack_latency", ack_at, LAT0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
